// File: rtl/di_loopback_fifo_terminal_pkg.sv
// Shared definitions for the di_* loopback FIFO terminal: register map,
// STATUS bit layout and read-side FSM encoding.
package di_loopback_fifo_terminal_pkg;

   localparam int unsigned DW = 16;

   // Register addresses within the terminal
   localparam logic [31:0] DI_FIFO_DATA   = 32'd0;
   localparam logic [31:0] DI_FIFO_COUNT  = 32'd1;
   localparam logic [31:0] DI_FIFO_STATUS = 32'd2;

   // STATUS write bits
   localparam int unsigned ST_BIT_FLUSH = 0;
   localparam int unsigned ST_BIT_CLEAR = 1;

   // STATUS read bits
   localparam int unsigned ST_BIT_OVERFLOW  = 0;
   localparam int unsigned ST_BIT_UNDERFLOW = 1;

   // Read-side FSM: RAM has 1-cycle read latency into the output register
   typedef enum logic [1:0] {
      RD_EMPTY = 2'd0,
      RD_FETCH = 2'd1,
      RD_VALID = 2'd2
   } rd_state_e;

   // Pack the sticky flags into the STATUS read word
   function automatic logic [DW-1:0] status_word(input logic ovf, input logic unf);
      logic [DW-1:0] w;
      w = '0;
      w[ST_BIT_OVERFLOW]  = ovf;
      w[ST_BIT_UNDERFLOW] = unf;
      return w;
   endfunction

endpackage

// File: rtl/di_sync_fifo_ram.sv
// DEPTH x 16 simple dual-port RAM with synchronous 1-cycle read, plus the
// write/read pointers and occupancy count that turn it into a FIFO store.
module di_sync_fifo_ram
   import di_loopback_fifo_terminal_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic          ifclk,
   input  logic          resetb,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          rd_en,
   input  logic          flush,
   output logic [DW-1:0] rdata,
   output logic [CW-1:0] ram_cnt,
   output logic          ram_full
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_q;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push;
   logic          do_rd;

   assign ram_cnt  = cnt_q;
   assign ram_full = (cnt_q == CW'(DEPTH));
   assign rdata    = rdata_q;

   // Pointer and count next-state; flush empties the store and beats push/read
   always_comb begin
      do_push = push && !ram_full && !flush;
      do_rd   = rd_en && (cnt_q != '0) && !flush;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + AW'(1);
         if (do_rd)   rptr_d = rptr_q + AW'(1);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_rd);
      end
   end

   // Storage array and registered read port; contents need no reset
   always_ff @(posedge ifclk) begin
      if (do_push) mem[wptr_q] <= wdata;
      if (do_rd)   rdata_q     <= mem[rptr_q];
   end

   // Pointer/count registers
   always_ff @(posedge ifclk) begin
      if (!resetb) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/di_loopback_fifo_terminal.sv
// Loopback FIFO terminal on the di_* bus: host writes words to DATA and
// reads them back in order, with COUNT/STATUS snapshot registers.
module di_loopback_fifo_terminal
   import di_loopback_fifo_terminal_pkg::*;
#(
   parameter logic [15:0] TERM_ADDR = 16'h0010,
   parameter int unsigned DEPTH     = 16
) (
   input  logic          ifclk,
   input  logic          resetb,
   input  logic [15:0]   di_term_addr,
   input  logic [31:0]   di_reg_addr,
   input  logic [DW-1:0] di_reg_datai,
   input  logic          di_read_req,
   input  logic          di_read,
   input  logic          di_write,
   input  logic          di_read_mode,
   input  logic          di_write_mode,
   output logic [DW-1:0] di_reg_datao,
   output logic          di_read_rdy,
   output logic          di_write_rdy,
   output logic [15:0]   fifo_count,
   output logic          overflow,
   output logic          underflow
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   rd_state_e     state_q, state_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [DW-1:0] snap_q, snap_d;
   logic          snap_pending_q, snap_pending_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic [15:0]   count_q, count_d;

   logic          sel, is_data, is_count, is_status;
   logic          push, pop, ovf_set, unf_set, flush, clear, snap_req;
   logic          rd_en, out_valid;
   logic [CW-1:0] ram_cnt;
   logic          ram_full;
   logic [DW-1:0] ram_rdata;
   logic          unused_mode;

   assign unused_mode = di_read_mode ^ di_write_mode;

   di_sync_fifo_ram #(.DEPTH(DEPTH)) u_ram (
      .ifclk    (ifclk),
      .resetb   (resetb),
      .push     (push),
      .wdata    (di_reg_datai),
      .rd_en    (rd_en),
      .flush    (flush),
      .rdata    (ram_rdata),
      .ram_cnt  (ram_cnt),
      .ram_full (ram_full)
   );

   // Address decode and per-cycle bus events
   always_comb begin
      sel       = (di_term_addr == TERM_ADDR);
      is_data   = (di_reg_addr == DI_FIFO_DATA);
      is_count  = (di_reg_addr == DI_FIFO_COUNT);
      is_status = (di_reg_addr == DI_FIFO_STATUS);
      out_valid = (state_q == RD_VALID);
      push      = sel && is_data && di_write && !ram_full;
      ovf_set   = sel && is_data && di_write && ram_full;
      pop       = sel && is_data && di_read && out_valid;
      unf_set   = sel && is_data && di_read && !out_valid;
      flush     = sel && is_status && di_write && di_reg_datai[ST_BIT_FLUSH];
      clear     = sel && is_status && di_write && di_reg_datai[ST_BIT_CLEAR];
      snap_req  = sel && di_read_req && !is_data;
   end

   // Read FSM: pull the RAM head into the output register, one word per pop
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      rd_en      = 1'b0;
      unique case (state_q)
         RD_EMPTY: begin
            if (ram_cnt != '0) begin
               rd_en   = 1'b1;
               state_d = RD_FETCH;
            end
         end
         RD_FETCH: begin
            out_data_d = ram_rdata;
            state_d    = RD_VALID;
         end
         RD_VALID: begin
            if (pop) begin
               if (ram_cnt != '0) begin
                  rd_en   = 1'b1;
                  state_d = RD_FETCH;
               end else begin
                  state_d = RD_EMPTY;
               end
            end
         end
         default: state_d = RD_EMPTY;
      endcase
      if (flush) begin
         state_d = RD_EMPTY;
         rd_en   = 1'b0;
      end
   end

   // Occupancy, sticky flags and COUNT/STATUS snapshot
   always_comb begin
      count_d        = count_q;
      overflow_d     = overflow_q;
      underflow_d    = underflow_q;
      snap_d         = snap_q;
      snap_pending_d = snap_pending_q;
      if (flush) count_d = '0;
      else       count_d = count_q + 16'(push) - 16'(pop);
      if (ovf_set) overflow_d  = 1'b1;
      if (unf_set) underflow_d = 1'b1;
      if (clear) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (snap_req) begin
         snap_pending_d = 1'b1;
         if (is_count)       snap_d = count_q;
         else if (is_status) snap_d = status_word(overflow_q, underflow_q);
         else                snap_d = '0;
      end
   end

   // State registers
   always_ff @(posedge ifclk) begin
      if (!resetb) begin
         state_q        <= RD_EMPTY;
         out_data_q     <= '0;
         snap_q         <= '0;
         snap_pending_q <= 1'b0;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
         count_q        <= '0;
      end else begin
         state_q        <= state_d;
         out_data_q     <= out_data_d;
         snap_q         <= snap_d;
         snap_pending_q <= snap_pending_d;
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
         count_q        <= count_d;
      end
   end

   assign di_write_rdy = sel && (!is_data || !ram_full);
   assign di_read_rdy  = sel && (is_data ? out_valid : (snap_pending_q && !di_read_req));
   assign di_reg_datao = is_data ? (out_valid ? out_data_q : '0) : snap_q;
   assign fifo_count   = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: doc/di_loopback_fifo_terminal.md
Name: di_loopback_fifo_terminal

Overview:
- Terminal on the HostInterface di_* bus, directly downstream of HostInterface and selected by di_term_addr == TERM_ADDR.
- Host writes 16-bit words into a FIFO at register DATA and reads them back in order.
- Read/write readiness comes from FIFO state, so the block exercises real di_read_rdy/di_write_rdy back-pressure plus count and sticky-error registers.
- Outputs feed the top-level di_reg_datao/di_read_rdy/di_write_rdy mux.

Parameters:
- TERM_ADDR, 16'h0010, terminal address this block answers to.
- DEPTH, 16, RAM word count; power of two, 2..32768. Total capacity is DEPTH+1 (RAM plus output register).
- AW, log2(DEPTH), RAM pointer width.

Ports:
- ifclk  in  1  clock; all logic on posedge.
- resetb  in  1  synchronous active-low reset.
- di_term_addr  in  16  terminal select.
- di_reg_addr  in  32  register within terminal: 0=DATA, 1=COUNT, 2=STATUS.
- di_reg_datai  in  16  write data.
- di_read_req  in  1  host announces read of the addressed register next.
- di_read  in  1  host consumes di_reg_datao this cycle.
- di_write  in  1  host presents di_reg_datai this cycle.
- di_read_mode  in  1  read transaction active; informational, unused.
- di_write_mode  in  1  write transaction active; informational, unused.
- di_reg_datao  out  16  registered read data.
- di_read_rdy  out  1  di_reg_datao valid for addressed register.
- di_write_rdy  out  1  write will be accepted.
- fifo_count  out  16  words held: RAM entries plus output valid.
- overflow  out  1  sticky: write dropped while full.
- underflow  out  1  sticky: di_read on DATA while empty.

Behaviour:
- Reset (resetb low at posedge):
  - Clears pointers, RAM count, out_valid, overflow, underflow, fifo_count and di_reg_datao to 0.
  - Sets read FSM to EMPTY and snap_pending to 0.
  - RAM contents are don't-care.
  - Applies mid-transaction too; in-flight data is discarded.
- sel = (di_term_addr == TERM_ADDR). When sel=0:
  - di_read_rdy=0 and di_write_rdy=0.
  - di_read and di_write are ignored; no state changes.
  - The FIFO keeps draining the RAM into the output register.
- Write path (sel=1):
  - DATA: di_write_rdy = !ram_full, where ram_full = (ram_cnt == DEPTH).
    - di_write && !ram_full: push into RAM.
    - di_write && ram_full: word dropped, overflow <= 1.
    - ram_full is the pre-edge value; a same-cycle pop does not make room.
  - STATUS: di_write_rdy=1. di_write applies bit0 = flush and bit1 = clear overflow/underflow.
  - COUNT and other addresses: di_write_rdy=1; writes ignored.
- Read FSM for DATA (RAM read latency 1):
  - EMPTY: out_valid=0. If ram_cnt>0, issue RAM read, go to FETCH.
  - FETCH: capture RAM output into the output register, out_valid=1, go to VALID.
  - VALID: on sel && DATA && di_read, pop. If ram_cnt>0, issue next RAM read and go to FETCH; otherwise go to EMPTY.
  - Consequence: one-cycle di_read_rdy bubble after every pop. Back-to-back reads run at 1 word per 2 cycles.
- DATA read rules:
  - di_read_rdy = out_valid; di_reg_datao = output register.
  - di_read while !out_valid: no pop, underflow <= 1, di_reg_datao stays 0.
- COUNT/STATUS reads:
  - di_read_req snapshots the value into di_reg_datao at the next edge.
  - di_read_rdy is 0 in the di_read_req cycle and 1 from the next cycle until the next di_read_req.
  - COUNT returns fifo_count; STATUS returns {14'b0, underflow, overflow}.
  - di_read has no side effect on COUNT or STATUS.
- Simultaneous push and pop: both occur; fifo_count is unchanged.
- Flush:
  - Clears pointers, ram_cnt and out_valid; FSM goes to EMPTY.
  - Wins over any same-cycle push.
  - Sticky flags are cleared only by bit1.
  - If bit0 and bit1 are set in the same word, both actions happen.
- fifo_count: registered, updated the same edge as push/pop/flush. Maximum value DEPTH+1.
- Pointers wrap modulo DEPTH; ram_cnt is AW+1 bits wide.

Decomposition:
- Shared defs include holds:
  - register address constants DI_FIFO_DATA=0, DI_FIFO_COUNT=1, DI_FIFO_STATUS=2;
  - STATUS bit positions (flush=0, clear=1, overflow=0, underflow=1);
  - FSM state encodings EMPTY/FETCH/VALID.
- Sub-module di_sync_fifo_ram: DEPTH x 16 simple dual-port RAM with synchronous 1-cycle read, write pointer, read pointer, ram_cnt and ram_full.
- The top level holds decode, FSM, output register, snapshot and sticky flags.

Test Plan:
- Reset and idle: hold resetb low 2 cycles, sel DATA -> di_write_rdy=1, di_read_rdy=0, fifo_count=0, di_reg_datao=0, overflow=0, underflow=0.
- Order and bubble: write 0x1111, 0x2222, 0x3333 on consecutive cycles -> di_read_rdy rises 2 cycles after first push. Reads return the same order with a 1-cycle gap between words; fifo_count goes 3,2,1,0.
- Full and overflow (DEPTH=4): 6 consecutive writes -> first 5 accepted. di_write_rdy goes low after the 4th RAM push; 6th word dropped; overflow=1. STATUS read via di_read_req returns 0x0001 one cycle later.
- Underflow and clear: di_read on empty DATA -> underflow=1, no count change. Writing STATUS 0x0002 clears both flags next cycle.
- Simultaneous push/pop: at count 2, di_write with di_read -> count stays 2; data order is preserved.
- Flush and deselect:
  - Write STATUS 0x0001 with 3 words queued -> count 0, di_read_rdy=0 next cycle.
  - With di_term_addr != TERM_ADDR, di_write pulses cause no count change and both rdy outputs stay 0.
